// File: rtl/data_mem_stage_if.sv
// Request/response bundle between the pipeline and the data-memory stage.
// The pipeline side is the master; the memory stage is the slave.
interface data_mem_stage_if #(
  parameter int n = 64
);
  logic [n-1:0] Address;
  logic [n-1:0] WriteData;
  logic         MemRead;
  logic         MemWrite;
  logic [n-1:0] ReadData;
  logic         Valid;
  logic         Busy;
  logic         Fault;

  modport master (
    output Address, WriteData, MemRead, MemWrite,
    input  ReadData, Valid, Busy, Fault
  );

  modport slave (
    input  Address, WriteData, MemRead, MemWrite,
    output ReadData, Valid, Busy, Fault
  );
endinterface

// File: rtl/data_mem_stage.sv
// LEGv8 data-memory stage: doubleword load/store with a fixed LAT-edge latency.
// Rejects misaligned, out-of-range and read+write requests with a one-cycle Fault.
module data_mem_stage #(
  parameter int n     = 64,
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  data_mem_stage_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, stateNext;
  logic [CW-1:0]   count;
  logic            isStore;
  logic [IW-1:0]   idx;
  logic [n-1:0]    wdata;
  logic [n-1:0]    readData;
  logic            valid, fault;
  logic [n-1:0]    mem [DEPTH];

  logic badRequest, accept, reject, complete;

  // Bits above the index field must all be zero: large addresses fault rather than wrap.
  assign badRequest = (|bus.Address[2:0])
                   || ((bus.Address >> (3 + IW)) != '0)
                   || (bus.MemRead && bus.MemWrite);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    reject    = 1'b0;
    complete  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.MemRead || bus.MemWrite) begin
          if (badRequest) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (count == '0) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count    <= '0;
      isStore  <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      readData <= '0;
      valid    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      valid <= complete;
      fault <= reject;
      if (accept) begin
        count   <= CW'(LAT - 1);
        isStore <= bus.MemWrite;
        idx     <= bus.Address[3 +: IW];
        wdata   <= bus.WriteData;
      end else if (state == WAIT && count != '0) begin
        count <= count - 1'b1;
      end
      if (complete && !isStore) begin
        readData <= mem[idx];
      end
    end
  end

  // NOTE: the array has no reset; a reset mid-access leaves state IDLE so the pending write never fires.
  always_ff @(posedge Clk) begin
    if (complete && isStore) begin
      mem[idx] <= wdata;
    end
  end

  assign bus.ReadData = readData;
  assign bus.Valid    = valid;
  assign bus.Fault    = fault;
  assign bus.Busy     = (state == WAIT);
endmodule

// File: tb/tb_data_mem_stage.sv
// Bench for data_mem_stage: an edge-timeline model checked every cycle on two
// builds (LAT=2 and LAT=1), plus directed vectors with literal expectations.
module tb_data_mem_stage;
  localparam int DEPTH = 256;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  data_mem_stage_if #(.n(64)) a ();
  data_mem_stage_if #(.n(64)) b ();

  data_mem_stage #(.n(64), .DEPTH(DEPTH), .LAT(2)) dutA (.Clk(Clk), .Reset_n(Reset_n), .bus(a));
  data_mem_stage #(.n(64), .DEPTH(DEPTH), .LAT(1)) dutB (.Clk(Clk), .Reset_n(Reset_n), .bus(b));

  int nChecks = 0;
  int nErrors = 0;
  bit chkEn = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted access completes at an absolute edge number (accept + LAT);
  // the stage is free again only on the edge after completion.
  longint      mEdge    [2];
  longint      mDone    [2];
  bit          mPending [2];
  bit          mStore   [2];
  int          mIdx     [2];
  logic [63:0] mData    [2];
  bit          mValid   [2];
  bit          mFault   [2];
  logic [63:0] mRd      [2];
  bit          mRdKnown [2];
  logic [63:0] mMem     [2][DEPTH];
  bit          mKnown   [2][DEPTH];

  initial begin
    for (int d = 0; d < 2; d++) begin
      mEdge[d] = 0; mDone[d] = 0; mPending[d] = 0; mStore[d] = 0; mIdx[d] = 0;
      mData[d] = '0; mValid[d] = 0; mFault[d] = 0; mRd[d] = '0; mRdKnown[d] = 1;
      for (int i = 0; i < DEPTH; i++) mKnown[d][i] = 0;
    end
  end

  task automatic modelReset(input int d);
    mPending[d] = 0; mValid[d] = 0; mFault[d] = 0; mRd[d] = '0; mRdKnown[d] = 1;
  endtask

  task automatic modelStep(input int d, input int lat, input logic rd, input logic wr,
                           input logic [63:0] addr, input logic [63:0] wd);
    mEdge[d]++;
    mValid[d] = 0;
    mFault[d] = 0;
    if (mPending[d]) begin
      if (mEdge[d] == mDone[d]) begin
        mPending[d] = 0;
        mValid[d]   = 1;
        if (mStore[d]) begin
          mMem[d][mIdx[d]]   = mData[d];
          mKnown[d][mIdx[d]] = 1;
        end else begin
          mRd[d]      = mMem[d][mIdx[d]];
          mRdKnown[d] = mKnown[d][mIdx[d]];
        end
      end
    end else if (rd || wr) begin
      if ((addr % 8) != 0 || addr >= 64'(DEPTH * 8) || (rd && wr)) begin
        mFault[d] = 1;
      end else begin
        mPending[d] = 1;
        mDone[d]    = mEdge[d] + lat;
        mStore[d]   = wr;
        mIdx[d]     = int'(addr / 8);
        mData[d]    = wd;
      end
    end
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      modelReset(0);
      modelReset(1);
    end else begin
      modelStep(0, 2, a.MemRead, a.MemWrite, a.Address, a.WriteData);
      modelStep(1, 1, b.MemRead, b.MemWrite, b.Address, b.WriteData);
    end
  end

  task automatic cmpDut(input string nm, input int d, input logic [63:0] rdat,
                        input logic v, input logic bz, input logic f);
    check({nm, "_valid"}, 64'(v),  64'(mValid[d]));
    check({nm, "_busy"},  64'(bz), 64'(mPending[d]));
    check({nm, "_fault"}, 64'(f),  64'(mFault[d]));
    if (mRdKnown[d]) check({nm, "_readdata"}, rdat, mRd[d]);
  endtask

  always @(negedge Clk) begin
    if (chkEn) begin
      cmpDut("A", 0, a.ReadData, a.Valid, a.Busy, a.Fault);
      cmpDut("B", 1, b.ReadData, b.Valid, b.Busy, b.Fault);
    end
  end

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [63:0] addr, input logic [63:0] wd);
    if (d == 0) begin
      a.MemRead = rd; a.MemWrite = wr; a.Address = addr; a.WriteData = wd;
    end else begin
      b.MemRead = rd; b.MemWrite = wr; b.Address = addr; b.WriteData = wd;
    end
  endtask

  task automatic sample(input int d, output logic v, output logic bz, output logic f,
                        output logic [63:0] rdat);
    if (d == 0) begin
      v = a.Valid; bz = a.Busy; f = a.Fault; rdat = a.ReadData;
    end else begin
      v = b.Valid; bz = b.Busy; f = b.Fault; rdat = b.ReadData;
    end
  endtask

  // Issues one request for one edge (optionally holding junk inputs while busy),
  // then waits a bounded number of cycles for Valid or Fault.
  task automatic op(input int d, input logic rd, input logic wr,
                    input logic [63:0] addr, input logic [63:0] wd, input bit junk,
                    output logic [63:0] rdOut, output int lat, output int busyCnt,
                    output bit gotV, output bit gotF);
    logic v, bz, f;
    logic [63:0] rdat;
    bit done;
    rdOut = '0; lat = 0; busyCnt = 0; gotV = 0; gotF = 0; done = 0;
    @(negedge Clk);
    drive(d, rd, wr, addr, wd);
    @(negedge Clk);
    if (junk) drive(d, 1'b0, 1'b1, 64'h20, 64'h3333);
    else      drive(d, 1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 10 && !done; i++) begin
      sample(d, v, bz, f, rdat);
      if (v || f) begin
        done = 1; lat = i; gotV = v; gotF = f; rdOut = rdat;
      end else begin
        if (bz) busyCnt++;
        @(negedge Clk);
      end
    end
    drive(d, 1'b0, 1'b0, '0, '0);
    check("op_finished", 64'(done), 64'd1);
  endtask

  logic [63:0] rdOut;
  int lat, busyCnt;
  bit gotV, gotF;
  logic [63:0] b2bAddr [3];
  logic [63:0] b2bVal  [3];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    #2 Reset_n = 1'b0;
    #1 chkEn = 1'b1;

    // Reset held with clock running and random inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("rst_readdata", a.ReadData, 64'd0);
      check("rst_flags", {61'd0, a.Valid, a.Busy, a.Fault}, 64'd0);
      drive(0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      drive(1, 1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
    end
    @(negedge Clk);
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    #2 Reset_n = 1'b1;

    // Store then load, LAT=2.
    op(0, 0, 1, 64'h10, 64'hDEADBEEFCAFEF00D, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("st_busy_cycles", 64'(busyCnt), 64'd2);
    check("st_valid", 64'(gotV), 64'd1);
    check("st_latency", 64'(lat), 64'd3);
    op(0, 1, 0, 64'h10, '0, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("ld_data", rdOut, 64'hDEADBEEFCAFEF00D);
    check("ld_latency", 64'(lat), 64'd3);

    // Rejections.
    op(0, 1, 0, 64'h13, '0, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("misaligned_fault", {62'd0, gotF, gotV}, 64'd2);
    check("misaligned_busy", 64'(busyCnt), 64'd0);
    check("misaligned_latency", 64'(lat), 64'd1);
    op(0, 1, 0, 64'h800, '0, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("range_fault", {62'd0, gotF, gotV}, 64'd2);
    op(0, 0, 1, 64'h8000_0000_0000_0010, 64'h77, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("range_high_fault", {62'd0, gotF, gotV}, 64'd2);
    op(0, 1, 1, 64'h8, '0, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("both_fault", {62'd0, gotF, gotV}, 64'd2);

    // Inputs ignored while busy.
    op(0, 0, 1, 64'h18, 64'h1111, 0, rdOut, lat, busyCnt, gotV, gotF);
    op(0, 0, 1, 64'h20, 64'h2222, 1, rdOut, lat, busyCnt, gotV, gotF);
    check("junk_no_fault", {62'd0, gotF, gotV}, 64'd1);
    op(0, 1, 0, 64'h20, '0, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("ld_0x20", rdOut, 64'h2222);
    op(0, 1, 0, 64'h18, '0, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("ld_0x18", rdOut, 64'h1111);

    // Reset one cycle into a store aborts it.
    op(0, 0, 1, 64'h28, 64'hAAAA, 0, rdOut, lat, busyCnt, gotV, gotF);
    @(negedge Clk);
    drive(0, 0, 1, 64'h28, 64'h5555);
    @(negedge Clk);
    drive(0, 0, 0, '0, '0);
    check("midrst_busy_before", 64'(a.Busy), 64'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_readdata", a.ReadData, 64'd0);
    check("midrst_flags", {61'd0, a.Valid, a.Busy, a.Fault}, 64'd0);
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    op(0, 1, 0, 64'h28, '0, 0, rdOut, lat, busyCnt, gotV, gotF);
    check("midrst_ld_0x28", rdOut, 64'hAAAA);

    // Back-to-back loads at the minimum interval on the LAT=1 build.
    b2bAddr[0] = 64'h0;  b2bVal[0] = 64'h0123_4567_89AB_CDEF;
    b2bAddr[1] = 64'h8;  b2bVal[1] = 64'hFEDC_BA98_7654_3210;
    b2bAddr[2] = 64'h10; b2bVal[2] = 64'h5A5A_A5A5_0F0F_F0F0;
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 1, b2bAddr[i], b2bVal[i], 0, rdOut, lat, busyCnt, gotV, gotF);
      check("b_st_latency", 64'(lat), 64'd2);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (i > 0) begin
        check("b2b_valid", {62'd0, b.Valid, b.Fault}, 64'd2);
        check("b2b_data", b.ReadData, b2bVal[i-1]);
      end
      drive(1, 1, 0, b2bAddr[i], '0);
      @(negedge Clk);
      check("b2b_busy", {62'd0, b.Busy, b.Valid}, 64'd2);
      drive(1, 0, 0, '0, '0);
    end
    @(negedge Clk);
    check("b2b_valid_last", {62'd0, b.Valid, b.Fault}, 64'd2);
    check("b2b_data_last", b.ReadData, b2bVal[2]);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
